pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer: program counter with jump/branch/call/ret and circular RAS.
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int AW        = 16,
  parameter int DISP_W    = 8,
  parameter int LABEL_W   = 11,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           stall,
  input  logic                           jmp,
  input  logic                           branch,
  input  logic                           call,
  input  logic                           ret,
  input  logic                           sel_rd,
  input  logic                           sel_label,
  input  logic                           sel_rm,
  input  logic [DISP_W-1:0]              disp,
  input  logic [LABEL_W-1:0]             label,
  input  logic [AW-1:0]                  rd,
  input  logic [AW-1:0]                  rm,
  output logic [AW-1:0]                  pc,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  localparam int c_PW = $clog2(RAS_DEPTH);
  localparam int c_CW = c_PW + 1;
  localparam logic [c_CW-1:0] c_DEPTH = c_CW'(RAS_DEPTH);

  typedef enum logic [2:0] {
    OP_HOLD   = 3'd0,
    OP_POP    = 3'd1,
    OP_UNDER  = 3'd2,
    OP_CALL   = 3'd3,
    OP_JMP    = 3'd4,
    OP_BRANCH = 3'd5,
    OP_SEQ    = 3'd6
  } op_t;

  logic [AW-1:0]   r_pc;
  logic [AW-1:0]   r_stack [RAS_DEPTH];
  logic [c_PW-1:0] r_sp;
  logic [c_CW-1:0] r_count;
  logic            r_ovf;
  logic            r_unf;

  op_t             w_op;
  logic [AW-1:0]   w_pc_nxt;
  logic [AW-1:0]   w_pc_inc;
  logic [AW-1:0]   w_target;
  logic [AW-1:0]   w_disp_sext;
  logic [c_PW-1:0] w_sp_dec;
  logic            w_full;
  logic            w_ovf_nxt;
  logic            w_unf_nxt;

  generate
    if (DISP_W < AW) begin : g_disp_ext
      assign w_disp_sext = {{(AW-DISP_W){disp[DISP_W-1]}}, disp};
    end else begin : g_disp_full
      assign w_disp_sext = disp;
    end
  endgenerate

  assign w_pc_inc = r_pc + 1'b1;
  assign w_sp_dec = r_sp - 1'b1;
  assign w_full   = (r_count == c_DEPTH);

  // Enabled sources are ORed; the label keeps the current PC's upper page bits.
  assign w_target = ({AW{sel_rd}}    & rd)
                  | ({AW{sel_label}} & {r_pc[AW-1:LABEL_W], label})
                  | ({AW{sel_rm}}    & rm);

  always_comb begin
    w_op = OP_SEQ;
    if (stall) begin
      w_op = OP_HOLD;
    end else if (ret) begin
      w_op = (r_count != '0) ? OP_POP : OP_UNDER;
    end else if (call) begin
      w_op = OP_CALL;
    end else if (jmp) begin
      w_op = OP_JMP;
    end else if (branch) begin
      w_op = OP_BRANCH;
    end
  end

  always_comb begin
    w_pc_nxt  = w_pc_inc;
    w_ovf_nxt = 1'b0;
    w_unf_nxt = 1'b0;
    unique case (w_op)
      OP_HOLD:   w_pc_nxt = r_pc;
      OP_POP:    w_pc_nxt = r_stack[w_sp_dec];
      OP_UNDER:  w_unf_nxt = 1'b1;
      OP_CALL: begin
        w_pc_nxt  = w_target;
        w_ovf_nxt = w_full;
      end
      OP_JMP:    w_pc_nxt = w_target;
      OP_BRANCH: w_pc_nxt = r_pc + w_disp_sext;
      default:   w_pc_nxt = w_pc_inc;
    endcase
  end

  // When full, r_sp already points at the oldest slot, so a push overwrites it.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_pc    <= '0;
      r_sp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_stack[i] <= '0;
      end
    end else begin
      r_pc  <= w_pc_nxt;
      r_ovf <= w_ovf_nxt;
      r_unf <= w_unf_nxt;
      if (w_op == OP_CALL) begin
        r_stack[r_sp] <= w_pc_inc;
        r_sp          <= r_sp + 1'b1;
        if (!w_full) begin
          r_count <= r_count + 1'b1;
        end
      end else if (w_op == OP_POP) begin
        r_sp    <= w_sp_dec;
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign pc            = r_pc;
  assign ras_count     = r_count;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// tb_pc_sequencer: directed and random checks against a queue-based model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  localparam int AW        = 16;
  localparam int DISP_W    = 8;
  localparam int LABEL_W   = 11;
  localparam int RAS_DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                clr, stall, jmp, branch, call, ret;
  logic                sel_rd, sel_label, sel_rm;
  logic [DISP_W-1:0]   disp;
  logic [LABEL_W-1:0]  label;
  logic [AW-1:0]       rd, rm;
  logic [AW-1:0]       pc;
  logic [2:0]          ras_count;
  logic                ras_overflow, ras_underflow;

  pc_sequencer #(
    .AW(AW), .DISP_W(DISP_W), .LABEL_W(LABEL_W), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .clr(clr), .stall(stall), .jmp(jmp), .branch(branch),
    .call(call), .ret(ret), .sel_rd(sel_rd), .sel_label(sel_label),
    .sel_rm(sel_rm), .disp(disp), .label(label), .rd(rd), .rm(rm),
    .pc(pc), .ras_count(ras_count), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference: return addresses kept as a plain queue, newest at the back.
  logic [15:0] m_pc;
  logic [15:0] m_ras[$];
  logic        m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    clr = 0; stall = 0; jmp = 0; branch = 0; call = 0; ret = 0;
    sel_rd = 0; sel_label = 0; sel_rm = 0;
    disp = '0; label = '0; rd = '0; rm = '0;
  endtask

  task automatic model_step();
    logic [15:0] tgt;
    tgt = (sel_rd ? rd : 16'h0) | (sel_label ? {m_pc[15:11], label} : 16'h0)
        | (sel_rm ? rm : 16'h0);
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (clr) begin
      m_pc = 16'h0;
      m_ras.delete();
    end else if (stall) begin
      m_pc = m_pc;
    end else if (ret) begin
      if (m_ras.size() > 0) m_pc = m_ras.pop_back();
      else begin
        m_pc  = m_pc + 16'd1;
        m_unf = 1'b1;
      end
    end else if (call) begin
      if (m_ras.size() == RAS_DEPTH) begin
        void'(m_ras.pop_front());
        m_ovf = 1'b1;
      end
      m_ras.push_back(m_pc + 16'd1);
      m_pc = tgt;
    end else if (jmp) begin
      m_pc = tgt;
    end else if (branch) begin
      m_pc = m_pc + {{8{disp[7]}}, disp};
    end else begin
      m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, "/pc"},  {16'h0, pc}, {16'h0, m_pc});
    chk({tag, "/cnt"}, {29'h0, ras_count}, 32'(m_ras.size()));
    chk({tag, "/ovf"}, {31'h0, ras_overflow}, {31'h0, m_ovf});
    chk({tag, "/unf"}, {31'h0, ras_underflow}, {31'h0, m_unf});
  endtask

  task automatic jump_to(input logic [15:0] a);
    idle(); jmp = 1; sel_rd = 1; rd = a;
    cycle("jump_to");
  endtask

  initial begin
    idle();
    clr = 1; stall = 1; call = 1;
    cycle("reset");
    chk("reset_pc", {16'h0, pc}, 32'h0);
    chk("reset_cnt", {29'h0, ras_count}, 32'h0);

    // wrap
    jump_to(16'hFFFF);
    idle(); cycle("wrap");
    chk("wrap_const", {16'h0, pc}, 32'h0000);

    // branch back and forward
    jump_to(16'h0010);
    idle(); branch = 1; disp = 8'hFC; cycle("br_neg");
    chk("br_neg_const", {16'h0, pc}, 32'h000C);
    idle(); branch = 1; disp = 8'h05; cycle("br_pos");
    chk("br_pos_const", {16'h0, pc}, 32'h0011);

    // label jump keeps page bits; no selects gives 0
    jump_to(16'hA123);
    idle(); jmp = 1; sel_label = 1; label = 11'h155; cycle("label");
    chk("label_const", {16'h0, pc}, 32'hA155);
    idle(); jmp = 1; cycle("nosel");
    chk("nosel_const", {16'h0, pc}, 32'h0000);

    // nested calls with overflow, then returns with underflow
    jump_to(16'h0001);
    for (int i = 0; i < 5; i++) begin
      idle(); call = 1; sel_rd = 1; rd = pc + 16'd1; cycle("call");
    end
    chk("ovf_const", {31'h0, ras_overflow}, 32'h1);
    chk("full_cnt", {29'h0, ras_count}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      idle(); ret = 1; cycle("ret");
      chk("ret_const", {16'h0, pc}, 32'(6 - i));
    end
    idle(); ret = 1; cycle("under");
    chk("unf_const", {31'h0, ras_underflow}, 32'h1);
    chk("unf_pc", {16'h0, pc}, 32'h4);
    idle(); cycle("flag_clear");

    // stall beats call; ret beats call
    idle(); call = 1; sel_rm = 1; rm = 16'h0020; cycle("call1");
    idle(); stall = 1; call = 1; sel_rd = 1; rd = 16'h1234; cycle("stall");
    chk("stall_pc", {16'h0, pc}, 32'h0020);
    chk("stall_cnt", {29'h0, ras_count}, 32'h1);
    idle(); call = 1; ret = 1; sel_rd = 1; rd = 16'h4444; cycle("callret");
    chk("callret_cnt", {29'h0, ras_count}, 32'h0);

    // reset mid-operation
    idle(); call = 1; sel_rd = 1; rd = 16'h0100; cycle("c_a");
    idle(); call = 1; sel_rd = 1; rd = 16'h0200; cycle("c_b");
    idle(); clr = 1; call = 1; stall = 1; sel_rd = 1; rd = 16'h0300; cycle("midclr");
    chk("midclr_pc", {16'h0, pc}, 32'h0);
    chk("midclr_cnt", {29'h0, ras_count}, 32'h0);
    idle(); ret = 1; cycle("post_clr_ret");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      idle();
      clr       = ($urandom_range(0, 39) == 0);
      stall     = ($urandom_range(0, 7) == 0);
      ret       = ($urandom_range(0, 3) == 0);
      call      = ($urandom_range(0, 2) == 0);
      jmp       = ($urandom_range(0, 4) == 0);
      branch    = ($urandom_range(0, 3) == 0);
      sel_rd    = 1'($urandom);
      sel_label = 1'($urandom);
      sel_rm    = ($urandom_range(0, 3) == 0);
      disp      = 8'($urandom);
      label     = 11'($urandom);
      rd        = 16'($urandom);
      rm        = 16'($urandom);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
